// File: rtl/ex_muldiv_pkg.sv
// Shared constants and types for the iterative M-extension multiply/divide unit.
package ex_muldiv_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned FUNC3_W = 3;

  localparam logic [OPC_W-1:0] OP        = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_32     = 7'b0111011;
  localparam logic [OPC_W-1:0] F7_MULDIV = 7'b0000001;

  localparam logic [FUNC3_W-1:0] F3_MUL    = 3'b000;
  localparam logic [FUNC3_W-1:0] F3_MULH   = 3'b001;
  localparam logic [FUNC3_W-1:0] F3_MULHSU = 3'b010;
  localparam logic [FUNC3_W-1:0] F3_MULHU  = 3'b011;
  localparam logic [FUNC3_W-1:0] F3_DIV    = 3'b100;
  localparam logic [FUNC3_W-1:0] F3_DIVU   = 3'b101;
  localparam logic [FUNC3_W-1:0] F3_REM    = 3'b110;
  localparam logic [FUNC3_W-1:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic f3_is_div(input logic [FUNC3_W-1:0] f3);
    return f3[2];
  endfunction

  // rs1 is signed for MULH, MULHSU, DIV, REM
  function automatic logic rs1_signed(input logic [FUNC3_W-1:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is signed for MULH, DIV, REM
  function automatic logic rs2_signed(input logic [FUNC3_W-1:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Issue/result handshake bundle between the pipeline and the multiply/divide unit.
interface ex_muldiv_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [2:0]       func3;
  logic [6:0]       func7;
  logic [XLEN-1:0]  data1;
  logic [XLEN-1:0]  data2;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;
  logic             illegal;

  modport master (
    output in_valid, opcode, func3, func7, data1, data2, tag_in, out_ready,
    input  in_ready, out_valid, result, tag_out, illegal
  );

  modport slave (
    input  in_valid, opcode, func3, func7, data1, data2, tag_in, out_ready,
    output in_ready, out_valid, result, tag_out, illegal
  );

endinterface

// File: rtl/ex_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
module muldiv_step #(
  parameter int unsigned W = 64
) (
  input  logic           div,
  input  logic [2*W-1:0] acc_in,
  input  logic [2*W-1:0] aux_in,
  input  logic [W-1:0]   q_in,
  output logic [2*W-1:0] acc_out,
  output logic [2*W-1:0] aux_out,
  output logic [W-1:0]   q_out
);

  localparam int unsigned PW = 2 * W;

  logic [PW-1:0] rem_sh;
  logic [PW-1:0] base;
  logic [PW-1:0] addend;
  logic [PW:0]   sum;

  // One adder serves both paths: add multiplicand, or subtract divisor via ~x + 1
  always_comb begin
    rem_sh  = {acc_in[PW-2:0], q_in[W-1]};
    base    = div ? rem_sh : acc_in;
    addend  = div ? ~aux_in : (q_in[0] ? aux_in : '0);
    sum     = {1'b0, base} + {1'b0, addend} + (PW+1)'(div);
    acc_out = acc_in;
    aux_out = aux_in;
    q_out   = q_in;
    if (div) begin
      acc_out = sum[PW] ? sum[PW-1:0] : rem_sh;
      q_out   = {q_in[W-2:0], sum[PW]};
    end else begin
      acc_out = sum[PW-1:0];
      aux_out = aux_in << 1;
      q_out   = q_in >> 1;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV M-extension multiply/divide unit, one radix-2 step per clock,
// operating on magnitudes with the sign applied when the result is registered.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input logic          clk,
  input logic          rst,
  input logic          flush,
  ex_muldiv_if.slave   bus
);

  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned CNT_W = $clog2(XLEN + 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    aux;
  logic [XLEN-1:0]  qr;
  logic [2:0]       f3;
  logic             is_w;
  logic             neg_q;
  logic             neg_r;

  logic [PW-1:0]    acc_nx;
  logic [PW-1:0]    aux_nx;
  logic [XLEN-1:0]  qr_nx;

  logic             dec_w, dec_div, dec_illegal, dec_special;
  logic             sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]  op_a, op_b, mag_a, mag_b, min_n, spec_res;

  logic [PW-1:0]    prod;
  logic [XLEN-1:0]  quo, rem_mag, rem, raw, fin;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // Accept-time decode: legality, operand views, magnitudes and early-out results
  always_comb begin
    dec_w       = (bus.opcode == OP_32);
    dec_div     = f3_is_div(bus.func3);
    sgn_a       = rs1_signed(bus.func3);
    sgn_b       = rs2_signed(bus.func3);
    dec_illegal = (bus.func7 != F7_MULDIV) || !((bus.opcode == OP) || dec_w) ||
                  (dec_w && ((XLEN != 64) || (bus.func3 == F3_MULH) ||
                             (bus.func3 == F3_MULHSU) || (bus.func3 == F3_MULHU)));
    if (dec_w) begin
      op_a  = sgn_a ? sext32(bus.data1[31:0]) : XLEN'(bus.data1[31:0]);
      op_b  = sgn_b ? sext32(bus.data2[31:0]) : XLEN'(bus.data2[31:0]);
      min_n = sext32(32'h8000_0000);
    end else begin
      op_a  = bus.data1;
      op_b  = bus.data2;
      min_n = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg       = sgn_a & op_a[XLEN-1];
    b_neg       = sgn_b & op_b[XLEN-1];
    mag_a       = a_neg ? -op_a : op_a;
    mag_b       = b_neg ? -op_b : op_b;
    div_zero    = (op_b == '0);
    div_ovf     = dec_div && sgn_a && (op_a == min_n) && (op_b == '1);
    dec_special = dec_div && (div_zero || div_ovf);
    spec_res    = '0;
    if (div_zero) begin
      spec_res = bus.func3[1] ? (dec_w ? sext32(bus.data1[31:0]) : bus.data1) : '1;
    end else if (div_ovf) begin
      spec_res = bus.func3[1] ? '0 : min_n;
    end
  end

  muldiv_step #(.W(XLEN)) u_step (
    .div     (f3[2]),
    .acc_in  (acc),
    .aux_in  (aux),
    .q_in    (qr),
    .acc_out (acc_nx),
    .aux_out (aux_nx),
    .q_out   (qr_nx)
  );

  // Sign fix-up and field selection applied to the final iteration's outputs
  always_comb begin
    prod    = neg_q ? -acc_nx : acc_nx;
    quo     = neg_q ? -qr_nx : qr_nx;
    rem_mag = acc_nx[XLEN-1:0];
    rem     = neg_r ? -rem_mag : rem_mag;
    case (f3)
      F3_MUL:                       raw = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: raw = prod[PW-1:XLEN];
      F3_DIV, F3_DIVU:              raw = quo;
      default:                      raw = rem;
    endcase
    fin = is_w ? sext32(raw[31:0]) : raw;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      acc           <= '0;
      aux           <= '0;
      qr            <= '0;
      f3            <= '0;
      is_w          <= 1'b0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.tag_out   <= '0;
      bus.illegal   <= 1'b0;
    end else if (flush) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            f3           <= bus.func3;
            is_w         <= dec_w;
            neg_q        <= a_neg ^ b_neg;
            neg_r        <= a_neg;
            bus.tag_out  <= bus.tag_in;
            bus.illegal  <= dec_illegal;
            bus.in_ready <= 1'b0;
            if (dec_illegal) begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.result    <= '0;
            end else if (dec_special) begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.result    <= spec_res;
            end else begin
              state <= CALC;
              cnt   <= dec_w ? CNT_W'(32) : CNT_W'(XLEN);
              acc   <= '0;
              aux   <= dec_div ? PW'(mag_b) : PW'(mag_a);
              // W divides park the 32-bit dividend at the top so its MSB shifts out first
              qr    <= dec_div ? (dec_w ? (mag_a << (XLEN - 32)) : mag_a) : mag_b;
            end
          end
        end
        CALC: begin
          acc <= acc_nx;
          aux <= aux_nx;
          qr  <= qr_nx;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.result    <= fin;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
